multiply_divide_unit: RTL

- Iterative RV32M execution unit; sits in the execute stage beside the ALU.
- Shares the ALU's operand bypass muxing and {funct7, funct3, opcode} decode style.
- Parametrised in XLEN; radix-2, one bit per cycle; start/busy/result_valid handshake so the pipeline stalls while busy.
- Adds behaviour the ALU lacks: multi-cycle sequencing, abort, and RISC-V divide-by-zero and overflow semantics.

---
 rtl/rv32m_pkg.sv | 45 ++++
 rtl/muldiv_operand_mux.sv | 39 +++
 rtl/multiply_divide_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions for the multiply/divide unit and its operand mux.
//   OP_REG / F7_MULDIV : legal {opcode, funct7} for an M-extension R-type op
//   funct3_e           : M operation select
//   state_e            : sequencer states
//   rs1_signed/rs2_signed : per-op operand signedness
package rv32m_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // operand_2 bypass select; every other code falls back to the register file
  localparam logic [1:0] MUX2_FWD  = 2'b01;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic rs1_signed(input funct3_e f);
    case (f)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM: rs1_signed = 1'b1;
      default:                            rs1_signed = 1'b0;
    endcase
  endfunction

  function automatic logic rs2_signed(input funct3_e f);
    case (f)
      F3_MULH, F3_DIV, F3_REM: rs2_signed = 1'b1;
      default:                 rs2_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_operand_mux.sv
// Operand bypass muxes plus sign/magnitude extraction (combinational).
//   i_mux1_select : 0 = bus_rs1, 1 = fwd_rs1
//   i_mux2_select : 01 = fwd_rs2, otherwise bus_rs2
//   i_rs*_signed  : treat the operand as two's complement
//   o_op*         : raw selected operands
//   o_mag*        : magnitudes (raw value when unsigned)
//   o_neg*        : operand is negative (only when signed)
module muldiv_operand_mux
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_mux1_select,
  input  logic [1:0]      i_mux2_select,
  input  logic [XLEN-1:0] i_bus_rs1,
  input  logic [XLEN-1:0] i_bus_rs2,
  input  logic [XLEN-1:0] i_fwd_rs1,
  input  logic [XLEN-1:0] i_fwd_rs2,
  input  logic            i_rs1_signed,
  input  logic            i_rs2_signed,
  output logic [XLEN-1:0] o_op1,
  output logic [XLEN-1:0] o_op2,
  output logic [XLEN-1:0] o_mag1,
  output logic [XLEN-1:0] o_mag2,
  output logic            o_neg1,
  output logic            o_neg2
);

  assign o_op1  = i_mux1_select ? i_fwd_rs1 : i_bus_rs1;
  assign o_op2  = (i_mux2_select == MUX2_FWD) ? i_fwd_rs2 : i_bus_rs2;

  assign o_neg1 = i_rs1_signed & o_op1[XLEN-1];
  assign o_neg2 = i_rs2_signed & o_op2[XLEN-1];

  // -MIN wraps to MIN, which read unsigned is the correct magnitude 2^(XLEN-1)
  assign o_mag1 = o_neg1 ? (~o_op1 + 1'b1) : o_op1;
  assign o_mag2 = o_neg2 ? (~o_op2 + 1'b1) : o_op2;

endmodule

// File: rtl/multiply_divide_unit.sv
// Iterative RV32M multiply/divide unit, radix-2 (one bit per cycle).
//   clk, reset_n          : clock, async active-low reset
//   start, flush          : request / abort of in-flight op
//   opcode, funct3, funct7: instruction decode
//   mux1/2_select, bus_*, Forward_* : operand bypass selection
//   busy                  : op in RUN, requests ignored
//   result_valid, result  : one-cycle completion pulse, held result
// Accept in IDLE -> XLEN cycles of RUN -> DONE (result_valid) -> IDLE.
module multiply_divide_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            mux1_select,
  input  logic [1:0]      mux2_select,
  input  logic [XLEN-1:0] bus_rs1,
  input  logic [XLEN-1:0] bus_rs2,
  input  logic [XLEN-1:0] Forward_rs1,
  input  logic [XLEN-1:0] Forward_rs2,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  // mul: {partial hi, multiplier shifting out}; div: {remainder, quotient shifting in}
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]     r_dividend;  // raw rs1, returned by REM on divide-by-zero
  funct3_e             r_f3;
  logic                r_neg;
  logic                r_dz;
  logic                r_ovf;
  logic [XLEN-1:0]     r_result;

  funct3_e             w_f3;
  logic                w_legal;
  logic                w_accept;
  logic                w_is_div;
  logic [XLEN-1:0]     w_op1, w_op2, w_mag1, w_mag2;
  logic                w_neg1, w_neg2;
  logic [XLEN:0]       w_madd;
  logic [XLEN:0]       w_dshift;
  logic [XLEN:0]       w_ddiff;
  logic                w_qbit;
  logic [XLEN-1:0]     w_drem;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo, w_rem;
  logic [XLEN-1:0]     w_final;

  assign w_f3     = funct3_e'(funct3);
  assign w_legal  = (opcode == OP_REG) && (funct7 == F7_MULDIV);
  assign w_accept = start && !flush && w_legal && (r_state == IDLE);
  assign w_is_div = funct3[2];

  muldiv_operand_mux #(.XLEN(XLEN)) u_opmux (
    .i_mux1_select (mux1_select),
    .i_mux2_select (mux2_select),
    .i_bus_rs1     (bus_rs1),
    .i_bus_rs2     (bus_rs2),
    .i_fwd_rs1     (Forward_rs1),
    .i_fwd_rs2     (Forward_rs2),
    .i_rs1_signed  (rs1_signed(w_f3)),
    .i_rs2_signed  (rs2_signed(w_f3)),
    .o_op1         (w_op1),
    .o_op2         (w_op2),
    .o_mag1        (w_mag1),
    .o_mag2        (w_mag2),
    .o_neg1        (w_neg1),
    .o_neg2        (w_neg2)
  );

  // Shift-add: add multiplicand into the high half when the multiplier LSB is set,
  // then shift the whole accumulator right, carry included.
  assign w_madd = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // Restoring divide: the borrow bit of the trial subtract decides the quotient bit.
  assign w_dshift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ddiff  = w_dshift - {1'b0, r_opnd};
  assign w_qbit   = ~w_ddiff[XLEN];
  assign w_drem   = w_qbit ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0];

  assign w_acc_nxt = r_f3[2] ? {w_drem, r_acc[XLEN-2:0], w_qbit}
                             : {w_madd, r_acc[XLEN-1:1]};

  assign w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = r_acc[XLEN-1:0];
  assign w_rem  = r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_f3)
      F3_MUL:                       w_final = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (r_dz)       w_final = '1;
        else if (r_ovf) w_final = W_MIN;
        else            w_final = r_neg ? (~w_quo + 1'b1) : w_quo;
      end
      F3_REM, F3_REMU: begin
        if (r_dz)       w_final = r_dividend;
        else if (r_ovf) w_final = '0;
        else            w_final = r_neg ? (~w_rem + 1'b1) : w_rem;
      end
      default: w_final = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_dividend <= '0;
      r_f3       <= F3_MUL;
      r_neg      <= 1'b0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= RUN;
            r_cnt      <= CNT_W'(XLEN);
            r_f3       <= w_f3;
            r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            r_opnd     <= w_is_div ? w_mag2 : w_mag1;
            r_dividend <= w_op1;
            // remainder follows the dividend; everything else is the XOR of signs
            r_neg      <= (w_f3 == F3_REM) ? w_neg1 : (w_neg1 ^ w_neg2);
            r_dz       <= w_is_div && (w_op2 == '0);
            r_ovf      <= ((w_f3 == F3_DIV) || (w_f3 == F3_REM)) &&
                          (w_op1 == W_MIN) && (w_op2 == '1);
          end
        end
        RUN: begin
          if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          if (!flush) r_result <= w_final;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The pulse and its value are presented during DONE; a flush in that cycle
  // suppresses both so the prior result stays visible.
  assign busy         = (r_state == RUN);
  assign result_valid = (r_state == DONE) && !flush;
  assign result       = result_valid ? w_final : r_result;

endmodule
